// File: rtl/msdap_pkg.sv
// Shared MSDAP loader constants, state encoding and rj_sum saturating adder.
package msdap_pkg;

   localparam int unsigned WORD_W        = 16;
   localparam int unsigned RJ_DEPTH      = 16;
   localparam int unsigned COEFF_DEPTH   = 512;
   localparam int unsigned RJ_AW         = 4;
   localparam int unsigned COEFF_AW      = 9;
   localparam int unsigned COEFF_FIELD_W = 9;
   localparam int unsigned BIT_CNT_W     = 4;
   localparam int unsigned RJ_IDX_W      = 5;
   localparam int unsigned COEFF_IDX_W   = 10;
   localparam int unsigned SUM_W         = 10;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      SHIFT,
      WRITE,
      DONE
   } loader_state_e;

   // Adds one rj field into the running sum, clamping at the coefficient memory depth.
   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0]         sum,
                                                input logic [COEFF_FIELD_W-1:0] field);
      logic [SUM_W:0] t;
      t = (SUM_W+1)'(sum) + (SUM_W+1)'(field);
      return (t > (SUM_W+1)'(COEFF_DEPTH)) ? SUM_W'(COEFF_DEPTH) : SUM_W'(t);
   endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// MSB-first serial-to-parallel shifter with bit counter and frame resync.
// FRAME_CHECK_EN: report resyncs and missing frames at word boundaries on err_c.
module serial_word_shifter
   import msdap_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic              wait_frame,
   input  logic              bit_valid,
   input  logic              in_bit,
   input  logic              frame,
   output logic [WORD_W-1:0] word_c,
   output logic              word_ready_c,
   output logic              miss_c,
   output logic              err_c
);

   logic [WORD_W-1:0]    sreg_q, sreg_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sreg_d       = sreg_q;
      cnt_d        = cnt_q;
      word_ready_c = 1'b0;
      miss_c       = 1'b0;
      err_c        = 1'b0;
      word_c       = {sreg_q[WORD_W-2:0], in_bit};
      if (clear) begin
         sreg_d = '0;
         cnt_d  = '0;
      end else if (enable && bit_valid) begin
         if (wait_frame) begin
            if (frame) begin
               sreg_d = WORD_W'(in_bit);
               cnt_d  = BIT_CNT_W'(1);
            end
         end else if (cnt_q == '0) begin
`ifdef FRAME_CHECK_EN
            if (!frame) begin
               miss_c = 1'b1;
               err_c  = 1'b1;
            end else begin
               sreg_d = WORD_W'(in_bit);
               cnt_d  = BIT_CNT_W'(1);
            end
`else
            sreg_d = WORD_W'(in_bit);
            cnt_d  = BIT_CNT_W'(1);
`endif
         end else if (frame) begin
            // Mid-word frame: drop the partial word and restart on this bit.
            sreg_d = WORD_W'(in_bit);
            cnt_d  = BIT_CNT_W'(1);
`ifdef FRAME_CHECK_EN
            err_c  = 1'b1;
`endif
         end else if (cnt_q == BIT_CNT_W'(WORD_W-1)) begin
            word_ready_c = 1'b1;
            sreg_d       = word_c;
            cnt_d        = '0;
         end else begin
            sreg_d = word_c;
            cnt_d  = cnt_q + BIT_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/coeff_loader.sv
// Loads rj words then sum(rj) coefficient words from the serial config stream.
// FRAME_CHECK_EN: enables the sticky frame_err resync/missing-frame flag.
module coeff_loader
   import msdap_pkg::*;
(
   input  logic                Sclk,
   input  logic                Reset_n,
   input  logic                start,
   input  logic                bit_valid,
   input  logic                in_bit,
   input  logic                frame,
   output logic [WORD_W-1:0]   in_data,
   output logic                rj_we,
   output logic [RJ_AW-1:0]    rj_addr,
   output logic                write_enable,
   output logic [COEFF_AW-1:0] coeffwrite,
   output logic                busy,
   output logic                load_done,
   output logic                frame_err
);

   loader_state_e          state_q, state_d;
   logic [WORD_W-1:0]      in_data_q, in_data_d;
   logic                   rj_we_q, rj_we_d;
   logic [RJ_AW-1:0]       rj_addr_q, rj_addr_d;
   logic                   write_enable_q, write_enable_d;
   logic [COEFF_AW-1:0]    coeffwrite_q, coeffwrite_d;
   logic                   busy_q, busy_d;
   logic                   load_done_q, load_done_d;
   logic                   frame_err_q, frame_err_d;
   logic [RJ_IDX_W-1:0]    rj_idx_q, rj_idx_d;
   logic [COEFF_IDX_W-1:0] coeff_idx_q, coeff_idx_d;
   logic [SUM_W-1:0]       rj_sum_q, rj_sum_d;

   logic              rj_phase_c, finish_c, shift_en_c, clear_c, wait_frame_c;
   logic [WORD_W-1:0] word_c;
   logic              word_ready_c, miss_c, err_c;

   // Sequence ends once all rj words are in and coeff writes reached the target.
   assign rj_phase_c   = rj_idx_q < RJ_IDX_W'(RJ_DEPTH);
   assign finish_c     = !rj_phase_c && (COEFF_IDX_W'(coeff_idx_q) >= COEFF_IDX_W'(rj_sum_q));
   assign shift_en_c   = (state_q == WAIT_FRAME) || (state_q == SHIFT) ||
                         ((state_q == WRITE) && !finish_c);
   assign clear_c      = (state_q == IDLE);
   assign wait_frame_c = (state_q == WAIT_FRAME);

   serial_word_shifter u_shifter (
      .clk          (Sclk),
      .rst_n        (Reset_n),
      .clear        (clear_c),
      .enable       (shift_en_c),
      .wait_frame   (wait_frame_c),
      .bit_valid    (bit_valid),
      .in_bit       (in_bit),
      .frame        (frame),
      .word_c       (word_c),
      .word_ready_c (word_ready_c),
      .miss_c       (miss_c),
      .err_c        (err_c)
   );

   always_comb begin
      state_d        = state_q;
      in_data_d      = in_data_q;
      rj_we_d        = 1'b0;
      rj_addr_d      = rj_addr_q;
      write_enable_d = 1'b0;
      coeffwrite_d   = coeffwrite_q;
      busy_d         = busy_q;
      load_done_d    = 1'b0;
      frame_err_d    = frame_err_q | err_c;
      rj_idx_d       = rj_idx_q;
      coeff_idx_d    = coeff_idx_q;
      rj_sum_d       = rj_sum_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = WAIT_FRAME;
               busy_d       = 1'b1;
               rj_addr_d    = '0;
               coeffwrite_d = '0;
               rj_idx_d     = '0;
               coeff_idx_d  = '0;
               rj_sum_d     = '0;
               frame_err_d  = 1'b0;
            end
         end
         WAIT_FRAME: begin
            if (bit_valid && frame) state_d = SHIFT;
         end
         SHIFT: begin
            if (word_ready_c) begin
               state_d   = WRITE;
               in_data_d = word_c;
               if (rj_phase_c) begin
                  rj_we_d   = 1'b1;
                  rj_addr_d = rj_idx_q[RJ_AW-1:0];
                  rj_idx_d  = rj_idx_q + RJ_IDX_W'(1);
                  rj_sum_d  = sat_add(rj_sum_q, word_c[COEFF_FIELD_W-1:0]);
               end else begin
                  write_enable_d = 1'b1;
                  coeffwrite_d   = coeff_idx_q[COEFF_AW-1:0];
                  coeff_idx_d    = coeff_idx_q + COEFF_IDX_W'(1);
               end
            end else if (miss_c) begin
               state_d = WAIT_FRAME;
            end
         end
         WRITE: begin
            if (finish_c) begin
               state_d     = DONE;
               load_done_d = 1'b1;
               busy_d      = 1'b0;
            end else if (miss_c) begin
               state_d = WAIT_FRAME;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Sclk) begin
      if (!Reset_n) begin
         state_q        <= IDLE;
         in_data_q      <= '0;
         rj_we_q        <= 1'b0;
         rj_addr_q      <= '0;
         write_enable_q <= 1'b0;
         coeffwrite_q   <= '0;
         busy_q         <= 1'b0;
         load_done_q    <= 1'b0;
         frame_err_q    <= 1'b0;
         rj_idx_q       <= '0;
         coeff_idx_q    <= '0;
         rj_sum_q       <= '0;
      end else begin
         state_q        <= state_d;
         in_data_q      <= in_data_d;
         rj_we_q        <= rj_we_d;
         rj_addr_q      <= rj_addr_d;
         write_enable_q <= write_enable_d;
         coeffwrite_q   <= coeffwrite_d;
         busy_q         <= busy_d;
         load_done_q    <= load_done_d;
         frame_err_q    <= frame_err_d;
         rj_idx_q       <= rj_idx_d;
         coeff_idx_q    <= coeff_idx_d;
         rj_sum_q       <= rj_sum_d;
      end
   end

   assign in_data      = in_data_q;
   assign rj_we        = rj_we_q;
   assign rj_addr      = rj_addr_q;
   assign write_enable = write_enable_q;
   assign coeffwrite   = coeffwrite_q;
   assign busy         = busy_q;
   assign load_done    = load_done_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: table-driven loads against a write-list model.
module tb_coeff_loader;

   logic        Sclk = 1'b0;
   logic        Reset_n, start, bit_valid, in_bit, frame;
   logic [15:0] in_data;
   logic        rj_we, write_enable, busy, load_done, frame_err;
   logic [3:0]  rj_addr;
   logic [8:0]  coeffwrite;

   always #5 Sclk = ~Sclk;

   coeff_loader dut (
      .Sclk         (Sclk),
      .Reset_n      (Reset_n),
      .start        (start),
      .bit_valid    (bit_valid),
      .in_bit       (in_bit),
      .frame        (frame),
      .in_data      (in_data),
      .rj_we        (rj_we),
      .rj_addr      (rj_addr),
      .write_enable (write_enable),
      .coeffwrite   (coeffwrite),
      .busy         (busy),
      .load_done    (load_done),
      .frame_err    (frame_err)
   );

   typedef struct packed {
      logic [8:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] rj_base;
      logic [15:0] rj_last;
      int unsigned max_gap;
      bit          rand_coef;
      int unsigned exp_coef;
   } case_t;

   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  last_wr_cyc = 0;
   int  both_cnt = 0;
   wr_t rj_obs[$];
   wr_t co_obs[$];

   // Observe the memory-side write ports away from the active edge.
   always @(negedge Sclk) begin
      cyc++;
      if (rj_we) begin
         rj_obs.push_back({5'b0, rj_addr, in_data});
         last_wr_cyc = cyc;
      end
      if (write_enable) begin
         co_obs.push_back({coeffwrite, in_data});
         last_wr_cyc = cyc;
      end
      if (rj_we && write_enable) both_cnt++;
      if (load_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic b, input logic f);
      @(posedge Sclk);
      #1;
      bit_valid = v;
      in_bit    = b;
      frame     = f;
   endtask

   task automatic pulse_start();
      @(posedge Sclk);
      #1;
      start     = 1'b1;
      bit_valid = 1'b0;
      @(posedge Sclk);
      #1;
      start     = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int unsigned gap);
      for (int i = 15; i >= 0; i--) begin
         int unsigned g;
         g = (gap == 0) ? 0 : $urandom_range(gap, 0);
         repeat (g) drive(1'b0, 1'($urandom), 1'($urandom));
         drive(1'b1, w[i], i == 15);
      end
   endtask

   task automatic wait_done(input int d0);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 200) begin
         @(negedge Sclk);
         t++;
      end
   endtask

   task automatic run_case(input int idx, input case_t c);
      logic [15:0] rj[16];
      logic [15:0] co[$];
      int          sum, target, d0, n;
      sum = 0;
      for (int k = 0; k < 16; k++) begin
         rj[k] = (k == 15) ? c.rj_last : c.rj_base;
         sum  += int'(rj[k] & 16'h01FF);
      end
      target = (sum > 512) ? 512 : sum;
      for (int k = 0; k < int'(c.exp_coef); k++)
         co.push_back(c.rand_coef ? 16'($urandom) : 16'(16'h8001 + k));
      rj_obs.delete();
      co_obs.delete();
      d0 = done_cnt;
      pulse_start();
      @(negedge Sclk);
      chk($sformatf("c%0d_busy_after_start", idx), 32'(busy), 32'd1);
      for (int k = 0; k < 16; k++) send_word(rj[k], c.max_gap);
      for (int k = 0; k < co.size(); k++) begin
         if (c.max_gap > 0 && k == 3) pulse_start();
         send_word(co[k], c.max_gap);
      end
      drive(1'b0, 1'b0, 1'b0);
      wait_done(d0);
      @(negedge Sclk);
      chk($sformatf("c%0d_done_pulses", idx), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("c%0d_done_latency", idx), 32'(done_cyc - last_wr_cyc), 32'd1);
      chk($sformatf("c%0d_busy_end", idx), 32'(busy), 32'd0);
      chk($sformatf("c%0d_frame_err", idx), 32'(frame_err), 32'd0);
      chk($sformatf("c%0d_rj_count", idx), 32'(rj_obs.size()), 32'd16);
      n = (rj_obs.size() < 16) ? rj_obs.size() : 16;
      for (int k = 0; k < n; k++)
         chk($sformatf("c%0d_rj%0d", idx, k), 32'(rj_obs[k]), 32'({9'(k), rj[k]}));
      chk($sformatf("c%0d_coef_count", idx), 32'(co_obs.size()), 32'(c.exp_coef));
      n = (co_obs.size() < target) ? co_obs.size() : target;
      for (int k = 0; k < n; k++)
         chk($sformatf("c%0d_co%0d", idx, k), 32'(co_obs[k]), 32'({9'(k), co[k]}));
      if (co_obs.size() > 0)
         chk($sformatf("c%0d_last_addr", idx), 32'(co_obs[co_obs.size()-1].addr), 32'(target - 1));
   endtask

   case_t cases[5];

   initial begin
      int n0, d0;
      logic err_exp;
      Reset_n   = 1'b0;
      start     = 1'b0;
      bit_valid = 1'b0;
      in_bit    = 1'b0;
      frame     = 1'b0;

      cases[0] = '{16'h0002, 16'h0002, 0, 1'b0, 32};
      cases[1] = '{16'h0000, 16'h0000, 0, 1'b1, 0};
      cases[2] = '{16'hFE25, 16'h002D, 0, 1'b1, 512};
      cases[3] = '{16'h0002, 16'h0002, 5, 1'b0, 32};
      cases[4] = '{16'h0001, 16'h7E03, 2, 1'b1, 18};

      repeat (3) @(posedge Sclk);
      @(negedge Sclk);
      chk("reset_data_addr", {in_data, 3'b0, coeffwrite, rj_addr}, 32'd0);
      chk("reset_ctrl", {27'd0, rj_we, write_enable, busy, load_done, frame_err}, 32'd0);
      @(posedge Sclk);
      #1 Reset_n = 1'b1;

      for (int i = 0; i < 5; i++) run_case(i, cases[i]);

      // Mid-word resync: 7-bit fragment then a framed 0xA5A5 as the only coefficient word.
      rj_obs.delete();
      co_obs.delete();
      d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < 16; k++) send_word((k == 15) ? 16'h0001 : 16'h0000, 0);
      drive(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) drive(1'b1, 1'(k), 1'b0);
      send_word(16'hA5A5, 0);
      drive(1'b0, 1'b0, 1'b0);
      @(negedge Sclk);
      chk("resync_we_latency", 32'(write_enable), 32'd1);
      chk("resync_data", 32'(in_data), 32'h0000A5A5);
      chk("resync_addr", 32'(coeffwrite), 32'd0);
      wait_done(d0);
      @(negedge Sclk);
      chk("resync_coef_count", 32'(co_obs.size()), 32'd1);
      chk("resync_done", 32'(done_cnt - d0), 32'd1);
`ifdef FRAME_CHECK_EN
      err_exp = 1'b1;
`else
      err_exp = 1'b0;
`endif
      chk("resync_frame_err", 32'(frame_err), 32'(err_exp));

      // Reset held 3 cycles in the middle of an active load.
      rj_obs.delete();
      co_obs.delete();
      pulse_start();
      for (int k = 0; k < 3; k++) send_word(16'h0005, 0);
      for (int k = 0; k < 8; k++) drive(1'b1, 1'($urandom), k == 0);
      @(posedge Sclk);
      #1;
      Reset_n   = 1'b0;
      bit_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge Sclk);
         @(negedge Sclk);
         chk($sformatf("midrst%0d_data_addr", k), {in_data, 3'b0, coeffwrite, rj_addr}, 32'd0);
         chk($sformatf("midrst%0d_ctrl", k),
             {27'd0, rj_we, write_enable, busy, load_done, frame_err}, 32'd0);
      end
      @(posedge Sclk);
      #1 Reset_n = 1'b1;
      n0 = rj_obs.size() + co_obs.size();
      for (int k = 0; k < 4; k++) send_word(16'($urandom), 0);
      drive(1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge Sclk);
      chk("post_rst_no_writes", 32'(rj_obs.size() + co_obs.size() - n0), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("both_strobes", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Upstream feeder for the MSDAP coefficient memory and the rj memory.
- Deserialises the bit-serial configuration stream (MSB first, frame-aligned) into 16-bit words.
- Routes the first RJ_DEPTH words to the rj memory, then sum(rj) words to the coefficient memory, generating write strobe, write address and data.
- Signals completion so the filter engine can start; single clock domain (Sclk).

Parameters:
- WORD_W, 16, serial word width and memory data width
- RJ_DEPTH, 16, number of rj words loaded first
- COEFF_DEPTH, 512, coefficient memory depth; coefficient address width is 9

Ports:
- Sclk  input  1  system clock, all logic on posedge
- Reset_n  input  1  synchronous active-low reset, sampled on posedge Sclk
- start  input  1  one-cycle pulse; begins a load sequence from IDLE
- bit_valid  input  1  qualifies in_bit/frame on this cycle
- in_bit  input  1  serial data bit, MSB first
- frame  input  1  high with bit_valid on the MSB of each word
- in_data  output  16  assembled word, feeds coefficient/rj memory data input
- rj_we  output  1  write strobe to rj memory
- rj_addr  output  4  rj write address
- write_enable  output  1  write strobe to coefficient memory
- coeffwrite  output  9  coefficient write address
- busy  output  1  high from accepted start until load_done
- load_done  output  1  one-cycle pulse when the sequence completes
- frame_err  output  1  sticky resync error flag (see Optional Feature)

Behaviour:
- Reset (Reset_n=0 at posedge) forces state IDLE; in_data=0, rj_we=0, rj_addr=0, write_enable=0, coeffwrite=0, busy=0, load_done=0, frame_err=0; bit counter, word counters and rj_sum cleared. Reset mid-load aborts with no further writes.
- States: IDLE -> (start) WAIT_FRAME -> (bit_valid&frame) SHIFT -> (16th valid bit) WRITE -> SHIFT/WAIT_FRAME/DONE -> IDLE.
- IDLE: start ignored when busy; start taken only in IDLE; busy asserted the cycle after start.
- WAIT_FRAME: bits with frame=0 are discarded. The bit with frame=1 is shifted in as bit 15 and the bit count becomes 1.
- SHIFT: each bit_valid shifts in_bit into the LSB side. Cycles without bit_valid hold all state.
- After the 16th valid bit the word is complete. The next cycle is WRITE: exactly one of rj_we/write_enable is high for one cycle, in_data holds the word, and the address is the current word index. Write latency is 1 Sclk after the 16th bit.
- Mid-word resync: frame=1 with bit_valid while bit count is 1..15 discards the partial word and restarts with that bit as MSB. No write occurs.
- rj phase: words 0..RJ_DEPTH-1 go to rj_addr 0..15. Each rj word's low 9 bits are added into a 10-bit rj_sum, saturating at COEFF_DEPTH (512).
- Coefficient phase starts after rj word 15. Target = rj_sum; coeffwrite counts 0..target-1.
- target=0: go to DONE directly after the last rj write, with no coefficient writes.
- target=512: the last write goes to address 511; coeffwrite never wraps past 511.
- DONE: load_done pulses for 1 cycle; busy drops in the same cycle; return to IDLE. Addresses hold their last value until the next start, which clears them.
- bit_valid arriving during a WRITE cycle is accepted as the next word's bit (no bubble required).
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro FRAME_CHECK_EN.
- Defined:
  - frame_err is set when a mid-word resync occurs, or when a frame=0 bit arrives where an MSB is expected after WRITE (that bit is then dropped and the FSM waits for frame).
  - frame_err is cleared only by reset or by an accepted start.
- Undefined: frame_err is tied 0. Missing frame at a word boundary is tolerated; the bit is treated as the next word's MSB.

Decomposition:
- Shared package msdap_pkg holds:
  - WORD_W, RJ_DEPTH, COEFF_DEPTH, address widths;
  - the loader state enum (IDLE, WAIT_FRAME, SHIFT, WRITE, DONE);
  - the 9-bit coefficient field width.
- One natural sub-module: serial_word_shifter, containing the 16-bit shift register, bit counter, frame resync, and a word_ready pulse. The FSM, counters and rj_sum stay in coeff_loader.

Test Plan:
- Reset held low 3 cycles during an active load -> all outputs 0, state IDLE, no strobes afterwards.
- start, then 16 rj words each 0x0002 and 32 coefficient words 0x8001+i -> rj_we pulses at addr 0..15; write_enable pulses at coeffwrite 0..31 with in_data matching; one load_done, busy low.
- All rj=0 -> zero write_enable pulses; load_done 1 cycle after the rj_addr 15 write.
- rj words summing to 600 -> rj_sum saturates 512; last write at coeffwrite 511; exactly 512 coefficient writes.
- frame pulsed at bit 7 of a word, then a full word 0xA5A5 -> partial discarded, single write of 0xA5A5; frame_err=1 only with FRAME_CHECK_EN.
- bit_valid gaps of 0..5 idle cycles between bits -> identical writes to the gap-free run; start during busy ignored.
